// File: rtl/clic_irq_responder.sv
// CLIC interrupt responder: qualifies CLIC offers against mode/level/enable, raises a trap
// request and closes the CLIC handshake. Define CLIC_IRQ_RESP_KILL_EN to build the kill path.
module clic_irq_responder #(
  parameter int N_SOURCE  = 256,
  parameter int PrioWidth = 8,
  parameter int ModeWidth = 2,
  localparam int SrcWidth = $clog2(N_SOURCE)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 irq_valid_i,
  output logic                 irq_ready_o,
  input  logic [SrcWidth-1:0]  irq_id_i,
  input  logic [PrioWidth-1:0] irq_level_i,
  input  logic [ModeWidth-1:0] irq_mode_i,
  input  logic                 irq_is_pcs_i,
  input  logic                 irq_kill_req_i,
  output logic                 irq_kill_ack_o,
  input  logic [ModeWidth-1:0] priv_mode_i,
  input  logic                 irq_enable_i,
  input  logic [PrioWidth-1:0] threshold_i,
  output logic                 take_req_o,
  input  logic                 take_ack_i,
  output logic [SrcWidth-1:0]  take_id_o,
  output logic [PrioWidth-1:0] take_level_o,
  output logic [ModeWidth-1:0] take_mode_o,
  output logic                 take_pcs_o
);

`ifdef CLIC_IRQ_RESP_KILL_EN
  typedef enum logic [1:0] {IDLE, WAIT, HSHK, KILL} state_e;
`else
  typedef enum logic [1:0] {IDLE, WAIT, HSHK} state_e;
`endif

  state_e state;
  logic   eligible;

  // Higher target mode always preempts; same mode needs enable and a level above threshold.
  assign eligible = irq_valid_i &
                    ((irq_mode_i > priv_mode_i) |
                     ((irq_mode_i == priv_mode_i) & irq_enable_i & (irq_level_i > threshold_i)));

`ifdef CLIC_IRQ_RESP_KILL_EN
  logic kill_ack_q;
  assign irq_kill_ack_o = kill_ack_q;
`else
  logic unused_kill_req;
  assign unused_kill_req = irq_kill_req_i;
  assign irq_kill_ack_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      take_req_o   <= 1'b0;
      irq_ready_o  <= 1'b0;
      take_id_o    <= '0;
      take_level_o <= '0;
      take_mode_o  <= '0;
      take_pcs_o   <= 1'b0;
`ifdef CLIC_IRQ_RESP_KILL_EN
      kill_ack_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (eligible) begin
            take_id_o    <= irq_id_i;
            take_level_o <= irq_level_i;
            take_mode_o  <= irq_mode_i;
            take_pcs_o   <= irq_is_pcs_i;
            take_req_o   <= 1'b1;
            state        <= WAIT;
          end
        end
        // Core commit beats both an abort request and a withdrawn offer.
        WAIT: begin
          if (take_ack_i) begin
            take_req_o  <= 1'b0;
            irq_ready_o <= 1'b1;
            state       <= HSHK;
`ifdef CLIC_IRQ_RESP_KILL_EN
          end else if (irq_kill_req_i) begin
            take_req_o <= 1'b0;
            kill_ack_q <= 1'b1;
            state      <= KILL;
`endif
          end else if (!eligible) begin
            take_req_o <= 1'b0;
            state      <= IDLE;
          end
        end
        HSHK: begin
          irq_ready_o <= 1'b0;
          state       <= IDLE;
        end
`ifdef CLIC_IRQ_RESP_KILL_EN
        KILL: begin
          kill_ack_q <= 1'b0;
          state      <= IDLE;
        end
`endif
        default: begin
          take_req_o  <= 1'b0;
          irq_ready_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clic_irq_responder.sv
// Directed bench for clic_irq_responder; covers the kill path when CLIC_IRQ_RESP_KILL_EN is set,
// otherwise checks that kill requests are ignored.
module tb_clic_irq_responder;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       irq_valid_i;
  logic       irq_ready_o;
  logic [7:0] irq_id_i;
  logic [7:0] irq_level_i;
  logic [1:0] irq_mode_i;
  logic       irq_is_pcs_i;
  logic       irq_kill_req_i;
  logic       irq_kill_ack_o;
  logic [1:0] priv_mode_i;
  logic       irq_enable_i;
  logic [7:0] threshold_i;
  logic       take_req_o;
  logic       take_ack_i;
  logic [7:0] take_id_o;
  logic [7:0] take_level_o;
  logic [1:0] take_mode_o;
  logic       take_pcs_o;

  int checks = 0;
  int errors = 0;

  clic_irq_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .irq_valid_i(irq_valid_i), .irq_ready_o(irq_ready_o),
    .irq_id_i(irq_id_i), .irq_level_i(irq_level_i), .irq_mode_i(irq_mode_i),
    .irq_is_pcs_i(irq_is_pcs_i), .irq_kill_req_i(irq_kill_req_i), .irq_kill_ack_o(irq_kill_ack_o),
    .priv_mode_i(priv_mode_i), .irq_enable_i(irq_enable_i), .threshold_i(threshold_i),
    .take_req_o(take_req_o), .take_ack_i(take_ack_i),
    .take_id_o(take_id_o), .take_level_o(take_level_o), .take_mode_o(take_mode_o),
    .take_pcs_o(take_pcs_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] id, input logic [7:0] level,
                               input logic [1:0] mode, input logic pcs);
    irq_valid_i  = valid;
    irq_id_i     = id;
    irq_level_i  = level;
    irq_mode_i   = mode;
    irq_is_pcs_i = pcs;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    applyStimulus(1'b0, 8'd0, 8'd0, 2'd0, 1'b0);
    irq_kill_req_i = 1'b0;
    take_ack_i     = 1'b0;
    priv_mode_i    = 2'd0;
    irq_enable_i   = 1'b1;
    threshold_i    = 8'h10;
    step();
    checkOutput("rst_req", take_req_o, 0);
    checkOutput("rst_ready", irq_ready_o, 0);
    checkOutput("rst_kill_ack", irq_kill_ack_o, 0);
    checkOutput("rst_id", take_id_o, 0);
    checkOutput("rst_pcs", take_pcs_o, 0);
    rst_i = 1'b0;

    // Basic take: id 5 level 0x20, ack three cycles after request
    applyStimulus(1'b1, 8'd5, 8'h20, 2'd0, 1'b1);
    step();
    checkOutput("t1_req", take_req_o, 1);
    checkOutput("t1_id", take_id_o, 5);
    checkOutput("t1_level", take_level_o, 8'h20);
    checkOutput("t1_pcs", take_pcs_o, 1);
    step();
    checkOutput("t1_wait_ready", irq_ready_o, 0);
    step();
    checkOutput("t1_wait_req", take_req_o, 1);
    take_ack_i = 1'b1;
    step();
    take_ack_i = 1'b0;
    checkOutput("t1_ready", irq_ready_o, 1);
    checkOutput("t1_ready_valid", irq_valid_i, 1);
    checkOutput("t1_req_drop", take_req_o, 0);
    irq_valid_i = 1'b0;
    step();
    checkOutput("t1_ready_one", irq_ready_o, 0);
    step();
    checkOutput("t1_idle_ready", irq_ready_o, 0);
    checkOutput("t1_idle_req", take_req_o, 0);

    // Level equal to threshold is not enough; higher mode wins regardless of enable
    applyStimulus(1'b1, 8'd7, 8'h10, 2'd0, 1'b0);
    step();
    step();
    checkOutput("t2_eq_thresh", take_req_o, 0);
    irq_mode_i   = 2'd3;
    irq_enable_i = 1'b0;
    step();
    checkOutput("t2_mode_req", take_req_o, 1);
    checkOutput("t2_mode", take_mode_o, 3);
    checkOutput("t2_id", take_id_o, 7);
    // Withdrawal of the offer
    irq_valid_i = 1'b0;
    step();
    checkOutput("t2_withdraw_req", take_req_o, 0);
    checkOutput("t2_withdraw_ready", irq_ready_o, 0);
    checkOutput("t2_hold_id", take_id_o, 7);
    irq_enable_i = 1'b1;

    // Threshold raised while waiting
    applyStimulus(1'b1, 8'd3, 8'h20, 2'd0, 1'b0);
    step();
    checkOutput("t3_req", take_req_o, 1);
    threshold_i = 8'h30;
    step();
    checkOutput("t3_thresh_drop", take_req_o, 0);
    threshold_i = 8'h10;
    irq_valid_i = 1'b0;

    // take_ack outside WAIT is ignored
    take_ack_i = 1'b1;
    step();
    checkOutput("t4_ack_idle_ready", irq_ready_o, 0);
    checkOutput("t4_ack_idle_req", take_req_o, 0);
    take_ack_i = 1'b0;

`ifdef CLIC_IRQ_RESP_KILL_EN
    applyStimulus(1'b1, 8'd4, 8'h20, 2'd0, 1'b0);
    step();
    checkOutput("k_req", take_req_o, 1);
    irq_kill_req_i = 1'b1;
    step();
    irq_kill_req_i = 1'b0;
    checkOutput("k_ack", irq_kill_ack_o, 1);
    checkOutput("k_ready", irq_ready_o, 0);
    checkOutput("k_req_drop", take_req_o, 0);
    irq_id_i = 8'd9;
    step();
    checkOutput("k_ack_one", irq_kill_ack_o, 0);
    checkOutput("k_no_reaccept", take_req_o, 0);
    step();
    checkOutput("k_new_req", take_req_o, 1);
    checkOutput("k_new_id", take_id_o, 9);
    take_ack_i     = 1'b1;
    irq_kill_req_i = 1'b1;
    step();
    take_ack_i     = 1'b0;
    irq_kill_req_i = 1'b0;
    checkOutput("kb_ready", irq_ready_o, 1);
    checkOutput("kb_kill_ack", irq_kill_ack_o, 0);
    irq_valid_i = 1'b0;
    step();
    checkOutput("kb_ready_one", irq_ready_o, 0);
    checkOutput("kb_kill_ack2", irq_kill_ack_o, 0);
`else
    applyStimulus(1'b1, 8'd4, 8'h20, 2'd0, 1'b0);
    step();
    checkOutput("nk_req", take_req_o, 1);
    irq_kill_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("nk_kill_ack", irq_kill_ack_o, 0);
      checkOutput("nk_req_hold", take_req_o, 1);
    end
    take_ack_i = 1'b1;
    step();
    take_ack_i     = 1'b0;
    irq_kill_req_i = 1'b0;
    checkOutput("nk_ready", irq_ready_o, 1);
    irq_id_i = 8'd9;
    step();
    checkOutput("nk_ready_one", irq_ready_o, 0);
    checkOutput("nk_no_reaccept", take_req_o, 0);
    step();
    checkOutput("nk_new_req", take_req_o, 1);
    checkOutput("nk_new_id", take_id_o, 9);
    irq_valid_i = 1'b0;
    step();
    checkOutput("nk_withdraw", take_req_o, 0);
`endif

    // Reset asserted during the handshake cycle
    applyStimulus(1'b1, 8'd6, 8'h40, 2'd1, 1'b1);
    priv_mode_i = 2'd1;
    step();
    checkOutput("r_req", take_req_o, 1);
    take_ack_i = 1'b1;
    step();
    take_ack_i = 1'b0;
    checkOutput("r_ready", irq_ready_o, 1);
    rst_i = 1'b1;
    #1;
    checkOutput("r_async_ready", irq_ready_o, 0);
    checkOutput("r_async_req", take_req_o, 0);
    checkOutput("r_async_id", take_id_o, 0);
    checkOutput("r_async_level", take_level_o, 0);
    checkOutput("r_async_mode", take_mode_o, 0);
    checkOutput("r_async_pcs", take_pcs_o, 0);
    checkOutput("r_async_kill", irq_kill_ack_o, 0);
    irq_valid_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();
    checkOutput("r_after_req", take_req_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
